// File: rtl/sys_bus_arbiter.sv
// Two-master arbiter for the core bus: the FMC bridge always wins, the internal
// sequencer uses req/ack, and read data is steered home by an owner-tag pipeline.
module sys_bus_arbiter #(
    parameter int ADDR_BITS    = 24,
    parameter int DATA_BITS    = 32,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [ADDR_BITS-1:0] fmc_addr,
    input  logic                 fmc_wr,
    input  logic                 fmc_rd,
    input  logic [DATA_BITS-1:0] fmc_wdata,
    output logic [DATA_BITS-1:0] fmc_rdata,
    output logic                 fmc_rvalid,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_BITS-1:0] m1_addr,
    input  logic [DATA_BITS-1:0] m1_wdata,
    output logic                 m1_ack,
    output logic [DATA_BITS-1:0] m1_rdata,
    output logic                 m1_starved,
    output logic                 err_proto,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic                 bus_wr,
    output logic                 bus_rd,
    output logic [DATA_BITS-1:0] bus_wdata,
    input  logic [DATA_BITS-1:0] bus_rdata
);

    localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_IDLE, ST_RD_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FMC, OWN_M1} owner_t;

    state_t               state_q, state_d;
    owner_t               owner_q [READ_LATENCY+1];
    owner_t               issue_owner;
    logic                 fmc_strobe;
    logic                 m1_issue;
    logic [CNT_BITS-1:0]  starve_cnt_q, starve_cnt_d;
    logic [ADDR_BITS-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_BITS-1:0] bus_wdata_q, bus_wdata_d;
    logic                 bus_wr_q, bus_wr_d;
    logic                 bus_rd_q, bus_rd_d;
    logic [DATA_BITS-1:0] fmc_rdata_q, fmc_rdata_d;
    logic                 fmc_rvalid_q, fmc_rvalid_d;
    logic [DATA_BITS-1:0] m1_rdata_q, m1_rdata_d;
    logic                 m1_ack_q, m1_ack_d;
    logic                 err_proto_q, err_proto_d;

    assign fmc_strobe = fmc_wr | fmc_rd;

    always_comb begin
        state_d      = state_q;
        issue_owner  = OWN_NONE;
        m1_issue     = 1'b0;
        starve_cnt_d = starve_cnt_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wr_d     = 1'b0;
        bus_rd_d     = 1'b0;
        fmc_rdata_d  = fmc_rdata_q;
        fmc_rvalid_d = 1'b0;
        m1_rdata_d   = m1_rdata_q;
        m1_ack_d     = 1'b0;
        err_proto_d  = err_proto_q | (fmc_wr & fmc_rd);

        if (fmc_strobe) begin
            // A simultaneous wr+rd strobe is executed as a write only.
            bus_addr_d  = fmc_addr;
            bus_wdata_d = fmc_wdata;
            bus_wr_d    = fmc_wr;
            bus_rd_d    = ~fmc_wr;
            if (!fmc_wr) begin
                issue_owner = OWN_FMC;
            end
        end else if (state_q == ST_IDLE && m1_req) begin
            m1_issue    = 1'b1;
            bus_addr_d  = m1_addr;
            bus_wdata_d = m1_wdata;
            if (m1_we) begin
                bus_wr_d = 1'b1;
                m1_ack_d = 1'b1;
            end else begin
                bus_rd_d    = 1'b1;
                issue_owner = OWN_M1;
                state_d     = ST_RD_WAIT;
            end
        end

        case (owner_q[READ_LATENCY])
            OWN_FMC: begin
                fmc_rdata_d  = bus_rdata;
                fmc_rvalid_d = 1'b1;
            end
            OWN_M1: begin
                m1_rdata_d = bus_rdata;
                m1_ack_d   = 1'b1;
                state_d    = ST_IDLE;
            end
            default: ;
        endcase

        if (m1_req && state_q == ST_IDLE && fmc_strobe) begin
            if (starve_cnt_q != CNT_BITS'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end else if (!m1_req || m1_issue) begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wr_q     <= 1'b0;
            bus_rd_q     <= 1'b0;
            fmc_rdata_q  <= '0;
            fmc_rvalid_q <= 1'b0;
            m1_rdata_q   <= '0;
            m1_ack_q     <= 1'b0;
            err_proto_q  <= 1'b0;
            for (int i = 0; i <= READ_LATENCY; i++) begin
                owner_q[i] <= OWN_NONE;
            end
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wr_q     <= bus_wr_d;
            bus_rd_q     <= bus_rd_d;
            fmc_rdata_q  <= fmc_rdata_d;
            fmc_rvalid_q <= fmc_rvalid_d;
            m1_rdata_q   <= m1_rdata_d;
            m1_ack_q     <= m1_ack_d;
            err_proto_q  <= err_proto_d;
            // Stage 0 lines up with bus_rd; the last stage lines up with its data.
            owner_q[0]   <= issue_owner;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                owner_q[i] <= owner_q[i-1];
            end
        end
    end

    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_wr     = bus_wr_q;
    assign bus_rd     = bus_rd_q;
    assign fmc_rdata  = fmc_rdata_q;
    assign fmc_rvalid = fmc_rvalid_q;
    assign m1_rdata   = m1_rdata_q;
    assign m1_ack     = m1_ack_q;
    assign err_proto  = err_proto_q;
    assign m1_starved = (starve_cnt_q >= CNT_BITS'(STARVE_LIMIT));

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Randomized bench for sys_bus_arbiter: a cycle-indexed reference model predicts
// bus issue, read returns per owner, starvation and protocol-error flags.
module tb_sys_bus_arbiter;

    localparam int AB   = 24;
    localparam int DB   = 32;
    localparam int RL   = 2;
    localparam int SL   = 16;
    localparam int NCYC = 3000;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [AB-1:0] fmc_addr;
    logic          fmc_wr;
    logic          fmc_rd;
    logic [DB-1:0] fmc_wdata;
    logic [DB-1:0] fmc_rdata;
    logic          fmc_rvalid;
    logic          m1_req;
    logic          m1_we;
    logic [AB-1:0] m1_addr;
    logic [DB-1:0] m1_wdata;
    logic          m1_ack;
    logic [DB-1:0] m1_rdata;
    logic          m1_starved;
    logic          err_proto;
    logic [AB-1:0] bus_addr;
    logic          bus_wr;
    logic          bus_rd;
    logic [DB-1:0] bus_wdata;
    logic [DB-1:0] bus_rdata;

    sys_bus_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .READ_LATENCY(RL), .STARVE_LIMIT(SL)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .fmc_addr(fmc_addr), .fmc_wr(fmc_wr), .fmc_rd(fmc_rd), .fmc_wdata(fmc_wdata),
        .fmc_rdata(fmc_rdata), .fmc_rvalid(fmc_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_starved(m1_starved),
        .err_proto(err_proto),
        .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    endtask

    // A pending read return: the cycle its valid/ack is due and who owns it.
    typedef struct {
        int due;
        bit m1;
    } ret_t;

    ret_t          pend[$];
    logic [DB-1:0] rdata_hist [0:NCYC+8];

    // Expected outputs for the next cycle, derived from the arbitration rules.
    logic          nx_bus_wr, nx_bus_rd, nx_m1_wack, nx_err, nx_starved;
    logic [AB-1:0] nx_bus_addr;
    logic [DB-1:0] nx_bus_wdata;
    logic [DB-1:0] e_fmc_rdata, e_m1_rdata;
    logic          e_fmc_rv, e_m1_ack, rd_ack;
    bit            m1_busy;
    int            starve_n;

    initial begin
        int fmc_pct, m1_pct, both_pct, rst_permil;
        bit abandoned, fmc_s, m1_elig;

        sys_rst   = 1'b1;
        fmc_addr  = '0; fmc_wr = 1'b0; fmc_rd = 1'b0; fmc_wdata = '0;
        m1_req    = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        bus_rdata = '0;
        nx_bus_wr = 1'b0; nx_bus_rd = 1'b0; nx_m1_wack = 1'b0; nx_err = 1'b0;
        nx_starved = 1'b0; nx_bus_addr = '0; nx_bus_wdata = '0;
        e_fmc_rdata = '0; e_m1_rdata = '0;
        m1_busy = 1'b0; starve_n = 0;

        repeat (3) @(posedge sys_clk);
        #1;

        for (int c = 0; c < NCYC; c++) begin
            cyc = c;

            // Read returns landing in this cycle.
            e_fmc_rv = 1'b0;
            rd_ack   = 1'b0;
            while (pend.size() > 0 && pend[0].due == c) begin
                if (pend[0].m1) begin
                    e_m1_rdata = rdata_hist[c-1];
                    rd_ack     = 1'b1;
                    m1_busy    = 1'b0;
                    $display("cyc %0d m1 read ack data=%h", c, e_m1_rdata);
                end else begin
                    e_fmc_rdata = rdata_hist[c-1];
                    e_fmc_rv    = 1'b1;
                    $display("cyc %0d fmc read return data=%h", c, e_fmc_rdata);
                end
                void'(pend.pop_front());
            end
            e_m1_ack = nx_m1_wack | rd_ack;
            if (nx_m1_wack) $display("cyc %0d m1 write ack", c);

            check_val("bus_wr", bus_wr, nx_bus_wr);
            check_val("bus_rd", bus_rd, nx_bus_rd);
            check_val("bus_addr", bus_addr, nx_bus_addr);
            if (nx_bus_wr) check_val("bus_wdata", bus_wdata, nx_bus_wdata);
            check_val("fmc_rvalid", fmc_rvalid, e_fmc_rv);
            check_val("fmc_rdata", fmc_rdata, e_fmc_rdata);
            check_val("m1_ack", m1_ack, e_m1_ack);
            check_val("m1_rdata", m1_rdata, e_m1_rdata);
            check_val("m1_starved", m1_starved, nx_starved);
            check_val("err_proto", err_proto, nx_err);

            // Traffic mix per phase: light, FMC-saturated, resets, protocol errors.
            fmc_pct = 30; m1_pct = 50; both_pct = 0; rst_permil = 0;
            if (c >= 800 && c < 1600) begin
                fmc_pct = (c >= 1000 && c < 1030) ? 100 : 95;
                m1_pct  = 70;
            end else if (c >= 1600 && c < 2400) begin
                fmc_pct = 40; rst_permil = 15;
            end else if (c >= 2400) begin
                fmc_pct = 40; both_pct = 5;
            end

            sys_rst = ($urandom_range(0, 999) < rst_permil);

            fmc_wr = 1'b0; fmc_rd = 1'b0;
            fmc_addr  = AB'($urandom);
            fmc_wdata = $urandom;
            if ($urandom_range(0, 99) < fmc_pct) begin
                if ($urandom_range(0, 99) < both_pct) begin
                    fmc_wr = 1'b1; fmc_rd = 1'b1;
                end else if ($urandom_range(0, 1) == 1) begin
                    fmc_wr = 1'b1;
                end else begin
                    fmc_rd = 1'b1;
                end
            end

            // Master-1 behaviour: hold until ack, occasionally abandon before issue.
            abandoned = 1'b0;
            if (m1_req && e_m1_ack) begin
                m1_req = 1'b0;
            end else if (m1_req && !m1_busy && $urandom_range(0, 19) == 0) begin
                m1_req    = 1'b0;
                abandoned = 1'b1;
            end
            if (!m1_req && !abandoned && $urandom_range(0, 99) < m1_pct) begin
                m1_req   = 1'b1;
                m1_we    = $urandom_range(0, 1) == 1;
                m1_addr  = AB'($urandom);
                m1_wdata = $urandom;
            end
            if (sys_rst) m1_req = 1'b0;

            bus_rdata     = $urandom;
            rdata_hist[c] = bus_rdata;

            // Reference model for this cycle's arbitration decision.
            fmc_s   = fmc_wr | fmc_rd;
            m1_elig = m1_req && !m1_busy;
            if (sys_rst) begin
                nx_bus_wr = 1'b0; nx_bus_rd = 1'b0; nx_m1_wack = 1'b0; nx_err = 1'b0;
                nx_bus_addr = '0; nx_bus_wdata = '0; nx_starved = 1'b0;
                e_fmc_rdata = '0; e_m1_rdata = '0;
                m1_busy = 1'b0; starve_n = 0;
                pend.delete();
            end else begin
                nx_err     = nx_err | (fmc_wr & fmc_rd);
                nx_bus_wr  = 1'b0;
                nx_bus_rd  = 1'b0;
                nx_m1_wack = 1'b0;
                if (fmc_s) begin
                    nx_bus_addr  = fmc_addr;
                    nx_bus_wdata = fmc_wdata;
                    nx_bus_wr    = fmc_wr;
                    nx_bus_rd    = !fmc_wr;
                    if (!fmc_wr) pend.push_back('{due: c + RL + 2, m1: 1'b0});
                    if (m1_elig) starve_n = (starve_n < SL) ? starve_n + 1 : SL;
                    else if (!m1_req) starve_n = 0;
                end else if (m1_elig) begin
                    nx_bus_addr  = m1_addr;
                    nx_bus_wdata = m1_wdata;
                    if (m1_we) begin
                        nx_bus_wr  = 1'b1;
                        nx_m1_wack = 1'b1;
                    end else begin
                        nx_bus_rd = 1'b1;
                        m1_busy   = 1'b1;
                        pend.push_back('{due: c + RL + 2, m1: 1'b1});
                    end
                    starve_n = 0;
                end else if (!m1_req) begin
                    starve_n = 0;
                end
                nx_starved = (starve_n >= SL);
            end

            @(posedge sys_clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
